// File: rtl/fetch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | fetch_pkg : shared types and constants for the instruction-fetch stage
// | Rev 1.0
// +----------------------------------------------------------------------------
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_PRIME = 2'd0,
    ST_RUN   = 2'd1,
    ST_ISR   = 2'd2
  } fetch_state_t;

  typedef enum logic [1:0] {
    SRC_NONE   = 2'd0,
    SRC_BRANCH = 2'd1,
    SRC_RTI    = 2'd2,
    SRC_IRQ    = 2'd3
  } redirect_src_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int unsigned PC_STEP   = 4;

endpackage
`default_nettype wire

// File: rtl/if_id_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | if_id_reg : IF/ID pipeline register with hold and flush (flush wins)
// | Rev 1.0
// +----------------------------------------------------------------------------
module if_id_reg
  import fetch_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            hold,
  input  logic            flush,
  input  logic [XLEN-1:0] instr_d,
  input  logic [XLEN-1:0] pc_d,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] pc,
  output logic            valid
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr <= XLEN'(NOP_INSTR);
      pc    <= '0;
      valid <= 1'b0;
    end else if (flush) begin
      instr <= XLEN'(NOP_INSTR);
      pc    <= '0;
      valid <= 1'b0;
    end else if (!hold) begin
      instr <= instr_d;
      pc    <= pc_d;
      valid <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | fetch_stage : PC, instruction-memory address and IF/ID register.
// | Define FETCH_IRQ_EN to build the interrupt / return-from-interrupt logic.
// | Rev 1.0
// +----------------------------------------------------------------------------
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter logic [XLEN-1:0] INT_VECTOR = 32'h0000_0100
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            hazard,
  input  logic            stall_mem,
  input  logic            branch_taken_ex,
  input  logic [XLEN-1:0] branch_target_ex,
  input  logic            interrupt,
  input  logic            rti,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rd_data,
  output logic [XLEN-1:0] instr_if_id,
  output logic [XLEN-1:0] pc_if_id,
  output logic            valid_if_id,
  output logic            flush_stall,
  output logic [XLEN-1:0] epc
);

  fetch_state_t    state, state_next;
  redirect_src_t   src;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] target;
  logic            redirect;
  logic            pending;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_PRIME;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_PRIME: state_next = ST_RUN;
`ifdef FETCH_IRQ_EN
      ST_RUN:   if (src == SRC_IRQ) state_next = ST_ISR;
      ST_ISR:   if (src == SRC_RTI) state_next = ST_RUN;
`endif
      default:  state_next = ST_RUN;
    endcase
  end

  // A stalled redirect is not accepted; EX keeps presenting it until stall_mem drops.
  always_comb begin
    src = SRC_NONE;
    if (state != ST_PRIME && !stall_mem) begin
      if (branch_taken_ex)                src = SRC_BRANCH;
`ifdef FETCH_IRQ_EN
      else if (state == ST_ISR && rti)     src = SRC_RTI;
      else if (state == ST_RUN && pending) src = SRC_IRQ;
`endif
    end

    case (src)
      SRC_RTI: target = epc;
      SRC_IRQ: target = INT_VECTOR;
      default: target = branch_target_ex;
    endcase

    redirect = (src != SRC_NONE);

    if (state == ST_PRIME)  imem_addr = RESET_PC;
    else if (stall_mem)     imem_addr = pc_q;
    else if (redirect)      imem_addr = target;
    else if (hazard)        imem_addr = pc_q;
    else                    imem_addr = pc_q + XLEN'(PC_STEP);
  end

  // The address issued this cycle is, by construction, next cycle's pc_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= RESET_PC;
      flush_stall <= 1'b0;
    end else begin
      pc_q        <= imem_addr;
      flush_stall <= redirect;
    end
  end

`ifdef FETCH_IRQ_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= 1'b0;
      epc     <= '0;
    end else begin
      if (src == SRC_IRQ) begin
        pending <= interrupt;
        epc     <= valid_if_id ? pc_if_id : pc_q;
      end else if (interrupt) begin
        pending <= 1'b1;
      end
    end
  end
`else
  logic unused_irq_inputs;
  assign pending           = 1'b0;
  assign epc               = '0;
  assign unused_irq_inputs = ^{interrupt, rti, pending};
`endif

  if_id_reg #(
    .XLEN (XLEN)
  ) u_if_id_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .hold    ((state == ST_PRIME) | stall_mem | hazard),
    .flush   (redirect),
    .instr_d (imem_rd_data),
    .pc_d    (pc_q),
    .instr   (instr_if_id),
    .pc      (pc_if_id),
    .valid   (valid_if_id)
  );

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | tb_fetch_stage : directed self-checking bench for fetch_stage
// | Rev 1.0
// +----------------------------------------------------------------------------
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hazard = 1'b0;
  logic        stall_mem = 1'b0;
  logic        branch_taken_ex = 1'b0;
  logic [31:0] branch_target_ex = '0;
  logic        interrupt = 1'b0;
  logic        rti = 1'b0;
  logic [31:0] imem_addr;
  logic [31:0] imem_rd_data = '0;
  logic [31:0] instr_if_id;
  logic [31:0] pc_if_id;
  logic        valid_if_id;
  logic        flush_stall;
  logic [31:0] epc;

  int tests = 0;
  int fails = 0;

  fetch_stage #(
    .XLEN       (32),
    .RESET_PC   (32'h0000_0000),
    .INT_VECTOR (32'h0000_0100)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .hazard           (hazard),
    .stall_mem        (stall_mem),
    .branch_taken_ex  (branch_taken_ex),
    .branch_target_ex (branch_target_ex),
    .interrupt        (interrupt),
    .rti              (rti),
    .imem_addr        (imem_addr),
    .imem_rd_data     (imem_rd_data),
    .instr_if_id      (instr_if_id),
    .pc_if_id         (pc_if_id),
    .valid_if_id      (valid_if_id),
    .flush_stall      (flush_stall),
    .epc              (epc)
  );

  always #5 clk = ~clk;

  // Synchronous instruction memory: each word is its address with a fixed pattern.
  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  always @(posedge clk) imem_rd_data <= word(imem_addr);

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic see(input string tag, input logic v, input logic [31:0] pc,
                     input logic [31:0] addr, input logic fs);
    check({tag, "/valid"}, {31'b0, valid_if_id}, {31'b0, v});
    check({tag, "/pc"},    pc_if_id,  pc);
    check({tag, "/addr"},  imem_addr, addr);
    check({tag, "/flush"}, {31'b0, flush_stall}, {31'b0, fs});
  endtask

  task automatic cyc;
    @(negedge clk);
  endtask

  task automatic clear_in;
    hazard = 1'b0; stall_mem = 1'b0; branch_taken_ex = 1'b0;
    interrupt = 1'b0; rti = 1'b0;
  endtask

  task automatic branch_to(input logic [31:0] t);
    branch_taken_ex = 1'b1;
    branch_target_ex = t;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) cyc;
    #1;
    see("reset", 1'b0, 32'h0, 32'h0, 1'b0);
    check("reset/instr", instr_if_id, 32'h0000_0013);
    check("reset/epc",   epc,         32'h0);

    // Reset release: PRIME, then sequential fetch
    cyc; rst_n = 1'b1; #1; check("prime/addr", imem_addr, 32'h0);
    cyc; #1; see("c1", 1'b0, 32'h0, 32'h4, 1'b0);
    cyc; #1; see("c2", 1'b1, 32'h0, 32'h8, 1'b0);
    check("c2/instr", instr_if_id, word(32'h0));
    cyc; #1; see("c3", 1'b1, 32'h4, 32'hC, 1'b0);

    // Load-use hazard for two cycles
    cyc; hazard = 1'b1; #1; see("hz1", 1'b1, 32'h8, 32'hC, 1'b0);
    cyc; #1;                see("hz2", 1'b1, 32'h8, 32'hC, 1'b0);
    cyc; hazard = 1'b0; #1; see("hz3", 1'b1, 32'h8, 32'h10, 1'b0);
    cyc; #1;                see("hz4", 1'b1, 32'hC, 32'h14, 1'b0);
    check("hz4/instr", instr_if_id, word(32'hC));

    // Branch overriding a hazard
    cyc; hazard = 1'b1; branch_to(32'h40); #1; see("br0", 1'b1, 32'h10, 32'h40, 1'b0);
    cyc; clear_in; #1; see("br1", 1'b0, 32'h0, 32'h44, 1'b1);
    cyc; #1;           see("br2", 1'b1, 32'h40, 32'h48, 1'b0);
    check("br2/instr", instr_if_id, word(32'h40));
    branch_to(32'h18); #1; check("br3/addr", imem_addr, 32'h18);
    cyc; clear_in; #1; see("br4", 1'b0, 32'h0, 32'h1C, 1'b1);
    cyc; #1;           see("br5", 1'b1, 32'h18, 32'h20, 1'b0);

`ifdef FETCH_IRQ_EN
    // Interrupt entry, masked nested request, RTI, retake of the pending request
    cyc; interrupt = 1'b1; #1; see("irq0", 1'b1, 32'h1C, 32'h24, 1'b0);
    cyc; interrupt = 1'b0; #1; see("irq1", 1'b1, 32'h20, 32'h100, 1'b0);
    cyc; interrupt = 1'b1; #1; see("irq2", 1'b0, 32'h0, 32'h104, 1'b1);
    check("irq2/epc", epc, 32'h20);
    cyc; interrupt = 1'b0; #1; see("isr0", 1'b1, 32'h100, 32'h108, 1'b0);
    cyc; rti = 1'b1; #1;       see("rti0", 1'b1, 32'h104, 32'h20, 1'b0);
    cyc; rti = 1'b0; #1;       see("retake", 1'b0, 32'h0, 32'h100, 1'b1);
    cyc; rti = 1'b1; #1;       see("rti1", 1'b0, 32'h0, 32'h20, 1'b1);
    check("rti1/epc", epc, 32'h20);
    cyc; rti = 1'b0; #1;       see("rti2", 1'b0, 32'h0, 32'h24, 1'b1);
    cyc; rti = 1'b1; #1;       see("rti_run", 1'b1, 32'h20, 32'h28, 1'b0);
    check("rti_run/instr", instr_if_id, word(32'h20));
    cyc; rti = 1'b0;
`else
    // Interrupt and RTI have no effect
    cyc; interrupt = 1'b1; rti = 1'b1; #1; see("noirq0", 1'b1, 32'h1C, 32'h24, 1'b0);
    cyc; clear_in; #1;                     see("noirq1", 1'b1, 32'h20, 32'h28, 1'b0);
    check("noirq1/epc", epc, 32'h0);
`endif

    // Branch waiting out a two-cycle stall_mem
    branch_to(32'h24); #1; check("st0/addr", imem_addr, 32'h24);
    cyc; clear_in; #1; see("st1", 1'b0, 32'h0, 32'h28, 1'b1);
    cyc; stall_mem = 1'b1; branch_to(32'h80); #1; see("st2", 1'b1, 32'h24, 32'h28, 1'b0);
    cyc; #1;                see("st3", 1'b1, 32'h24, 32'h28, 1'b0);
    cyc; stall_mem = 1'b0; #1; see("st4", 1'b1, 32'h24, 32'h80, 1'b0);
    cyc; clear_in; #1;      see("st5", 1'b0, 32'h0, 32'h84, 1'b1);
    cyc; #1;                see("st6", 1'b1, 32'h80, 32'h88, 1'b0);

    // PC wrap at the top of the address space
    branch_to(32'hFFFF_FFFC); #1; check("wr0/addr", imem_addr, 32'hFFFF_FFFC);
    cyc; clear_in; #1; see("wr1", 1'b0, 32'h0, 32'h0, 1'b1);
    cyc; #1;           see("wr2", 1'b1, 32'hFFFF_FFFC, 32'h4, 1'b0);
    check("wr2/instr", instr_if_id, word(32'hFFFF_FFFC));
    interrupt = 1'b1;

    // Reset mid-operation discards IF/ID, state and any pending request
    cyc; interrupt = 1'b0; rst_n = 1'b0; #1;
    see("mrst", 1'b0, 32'h0, 32'h0, 1'b0);
    check("mrst/instr", instr_if_id, 32'h0000_0013);
    check("mrst/epc",   epc,         32'h0);
    cyc; rst_n = 1'b1; #1; check("mrst/prime", imem_addr, 32'h0);
    cyc; #1; see("mrst/run", 1'b0, 32'h0, 32'h4, 1'b0);
    cyc; #1; see("mrst/first", 1'b1, 32'h0, 32'h8, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the five-stage core: owns the PC, drives the synchronous instruction memory and loads the IF/ID pipeline register. It sits directly upstream of the hazard unit. It consumes that unit's `hazard` (load-use) and `stall_mem` (full freeze) signals. It produces the `flush_stall` pulse the hazard unit uses to start a pipeline freeze after any control-flow redirect (branch, interrupt entry, RTI).

## Interface
- `XLEN`, 32: PC and instruction width.
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.
- `INT_VECTOR`, 32'h0000_0100: interrupt handler entry address.
- `clk`  in  1  core clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `hazard`  in  1  load-use stall: hold PC and IF/ID.
- `stall_mem`  in  1  full pipeline freeze: hold everything, accept no redirect.
- `branch_taken_ex`  in  1  taken branch/jump resolved in EX.
- `branch_target_ex`  in  XLEN  target for `branch_taken_ex`.
- `interrupt`  in  1  level interrupt request.
- `rti`  in  1  return-from-interrupt resolved in EX.
- `imem_addr`  out  XLEN  combinational read address; data returns next cycle.
- `imem_rd_data`  in  XLEN  instruction for the address issued last cycle.
- `instr_if_id`  out  XLEN  IF/ID instruction.
- `pc_if_id`  out  XLEN  IF/ID PC.
- `valid_if_id`  out  1  IF/ID holds a real instruction.
- `flush_stall`  out  1  one-cycle registered redirect pulse to the hazard unit.
- `epc`  out  XLEN  saved interrupt return PC.

## Operation
- `pc_q` is the address whose data is on `imem_rd_data` this cycle.
- FSM states:
  - PRIME: first cycle after reset; `imem_addr`=`RESET_PC`; moves to RUN.
  - RUN: normal fetch.
  - ISR: handler running; interrupts masked.
- Per-cycle priority in RUN/ISR, highest first:
  1. `stall_mem`: hold all state, `imem_addr`=`pc_q`.
  2. Redirect: IF/ID←{NOP, 0, valid 0}, `pc_q`←target, `imem_addr`=target.
  3. `hazard`: hold `pc_q` and IF/ID, `imem_addr`=`pc_q`.
  4. Advance: IF/ID←{`imem_rd_data`, `pc_q`, 1}, `pc_q`←`pc_q`+4, `imem_addr`=`pc_q`+4.
- Redirect source priority: branch > rti > interrupt.
  - A redirect overrides `hazard`, because the ID instruction is on the wrong path.
- `interrupt` sets a `pending` flop.
- `pending` is taken in RUN on a cycle with no `stall_mem` and no branch:
  - `epc`←`valid_if_id` ? `pc_if_id` : `pc_q`.
  - Target `INT_VECTOR`; clear `pending`; state→ISR.
- In ISR, `pending` may set but is not taken.
- `rti` in ISR: target `epc`; state→RUN. `rti` in RUN is ignored.
- Branch and `rti` asserted in the same cycle: branch wins and `rti` is dropped.
- PC arithmetic is modulo 2^XLEN; 32'hFFFF_FFFC+4 wraps to 0.
- Reset asserted mid-operation discards `pending`, the FSM state and IF/ID contents immediately.

## Timing
- Reset values:
  - `pc_q`=`RESET_PC`, state PRIME, `imem_addr`=`RESET_PC`.
  - `instr_if_id`=NOP (32'h0000_0013), `pc_if_id`=0, `valid_if_id`=0.
  - `flush_stall`=0, `epc`=0, `pending`=0.
- The first valid IF/ID appears 2 cycles after `rst_n` rises (PRIME, then RUN advance).
- Redirect to valid target instruction in IF/ID takes 2 cycles: one bubble cycle, then the target fetched.
- `flush_stall` is high exactly the cycle after a redirect is accepted, never longer.
- A redirect presented during `stall_mem` waits. EX holds it stable until `stall_mem` falls.

## Configuration
- `FETCH_IRQ_EN` defined: interrupt/RTI logic as above.
- `FETCH_IRQ_EN` undefined:
  - `interrupt` and `rti` are ignored.
  - `pending` and ISR are removed.
  - `epc` is tied 0.
  - Only branches redirect and pulse `flush_stall`.

## Structure
- `fetch_pkg` holds:
  - the state enum (PRIME, RUN, ISR);
  - the `NOP_INSTR` constant;
  - the `PC_STEP`=4 constant;
  - a redirect-source enum (NONE, BRANCH, RTI, IRQ).
- One sub-module, `if_id_reg`: IF/ID register with hold and flush inputs; flush has priority over hold.

## Test plan
- Reset release, memory holds sequential words at 0,4,8 → `valid_if_id` rises cycle 2; `pc_if_id` = 0, 4, 8 on consecutive cycles; `flush_stall`=0 throughout.
- `hazard` held 2 cycles while `pc_if_id`=8 → IF/ID holds 8, `imem_addr` holds 12, then resumes 12, 16.
- `branch_taken_ex` with target 32'h40 alongside `hazard` → next `valid_if_id`=0, `flush_stall`=1 one cycle, then `pc_if_id`=32'h40.
- `interrupt` pulse while `pc_if_id`=32'h20 valid → `epc`=32'h20; fetch goes to 32'h100; a second interrupt in ISR is not taken; `rti` returns `pc_if_id`=32'h20.
- `branch_taken_ex` arriving during a 2-cycle `stall_mem` → no PC change while stalled; redirect accepted the first cycle `stall_mem`=0.
- `pc_q`=32'hFFFF_FFFC advancing → next `imem_addr`=0.
